// File: rtl/synapse_accumulator_pkg.sv
// Shared types and helpers for the synapse accumulator.
package synapse_accumulator_pkg;

    // Accumulator sequencer states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) is 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

    // Entry index width; never narrower than one bit so a single-entry table still has a port
    function automatic int unsigned idx_width(input int unsigned n_conn);
        return (n_conn > 1) ? clog2(n_conn) : 1;
    endfunction

endpackage

// File: rtl/synapse_accumulator_if.sv
// Configuration, spike and result signals of one synapse accumulator.
interface synapse_accumulator_if #(
    parameter int unsigned N_CONN   = 5,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned ACC_W    = 24
) ();
    import synapse_accumulator_pkg::*;

    localparam int unsigned IDX_W = idx_width(N_CONN);

    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [ADDR_W-1:0]   cfg_addr;
    logic [WEIGHT_W-1:0] cfg_weight;
    logic                cfg_en;
    logic                spike_valid;
    logic [ADDR_W-1:0]   spike_addr;
    logic                timestep_end;
    logic [ACC_W-1:0]    acc_out;
    logic                acc_valid;
    logic                busy;
    logic                overrun;

    // Master drives the table, spikes and timestep boundary
    modport master (
        output cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
        output spike_valid, spike_addr, timestep_end,
        input  acc_out, acc_valid, busy, overrun
    );

    // Slave is the accumulator itself
    modport slave (
        input  cfg_we, cfg_idx, cfg_addr, cfg_weight, cfg_en,
        input  spike_valid, spike_addr, timestep_end,
        output acc_out, acc_valid, busy, overrun
    );

endinterface

// File: rtl/synapse_match.sv
// Parallel source-address comparators, one per table entry, gated by the entry enable.
module synapse_match #(
    parameter int unsigned N_CONN = 5,
    parameter int unsigned ADDR_W = 12
) (
    input  logic [ADDR_W-1:0]             spike_addr,
    input  logic [N_CONN-1:0][ADDR_W-1:0] tab_addr,
    input  logic [N_CONN-1:0]             tab_en,
    output logic [N_CONN-1:0]             match
);

    // Every enabled entry holding the spike's address matches; duplicates all fire
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(N_CONN); i++) begin
            match[i] = tab_en[i] && (tab_addr[i] == spike_addr);
        end
    end

endmodule

// File: rtl/synapse_accumulator.sv
// Per-neuron synaptic accumulator: marks matching spikes during a timestep, then on
// timestep_end snapshots them and sums the weights of spiking entries serially with
// saturation, one entry per cycle.
module synapse_accumulator #(
    parameter int unsigned N_CONN   = 5,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned WEIGHT_W = 16,
    parameter int unsigned ACC_W    = 24
) (
    input logic                  CLK,
    input logic                  reset,
    synapse_accumulator_if.slave bus
);
    import synapse_accumulator_pkg::*;

    localparam int unsigned IDX_W = idx_width(N_CONN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CONN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W - 1){1'b0}}};

    state_e state_q, state_d;

    logic [N_CONN-1:0][ADDR_W-1:0]   tab_addr_q;
    logic [N_CONN-1:0][WEIGHT_W-1:0] tab_weight_q;
    logic [N_CONN-1:0]               tab_en_q;

    logic [N_CONN-1:0] incoming_q, incoming_d;
    logic [N_CONN-1:0] active_q, active_d;
    logic [N_CONN-1:0] match;
    logic [N_CONN-1:0] capture;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] acc_out_q, acc_out_d;
    logic             acc_valid_q, acc_valid_d;
    logic             overrun_q, overrun_d;

    logic idle;
    logic start;
    logic cfg_write;

    logic [WEIGHT_W-1:0] cur_weight;
    logic [ACC_W:0]      weight_ext;
    logic [ACC_W:0]      sum;
    logic [ACC_W-1:0]    sum_sat;

    assign idle      = (state_q == StIdle);
    assign start     = bus.timestep_end && idle;
    // Writes while busy and writes to nonexistent entries are dropped
    assign cfg_write = bus.cfg_we && idle && (32'(bus.cfg_idx) < N_CONN);

    synapse_match #(
        .N_CONN (N_CONN),
        .ADDR_W (ADDR_W)
    ) u_match (
        .spike_addr (bus.spike_addr),
        .tab_addr   (tab_addr_q),
        .tab_en     (tab_en_q),
        .match      (match)
    );

    assign capture = bus.spike_valid ? match : '0;

    // Entry table; cleared to disabled entries on reset
    always_ff @(posedge CLK) begin
        if (reset) begin
            tab_addr_q   <= '0;
            tab_weight_q <= '0;
            tab_en_q     <= '0;
        end else if (cfg_write) begin
            tab_addr_q[bus.cfg_idx]   <= bus.cfg_addr;
            tab_weight_q[bus.cfg_idx] <= bus.cfg_weight;
            tab_en_q[bus.cfg_idx]     <= bus.cfg_en;
        end
    end

    // Saturating add of the current entry's sign-extended weight, one guard bit wide
    always_comb begin
        cur_weight = tab_weight_q[idx_q];
        weight_ext = {{(ACC_W + 1 - WEIGHT_W){cur_weight[WEIGHT_W-1]}}, cur_weight};
        sum        = {acc_q[ACC_W-1], acc_q} + weight_ext;
        if (sum[ACC_W] != sum[ACC_W-1]) begin
            sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum[ACC_W-1:0];
        end
    end

    // Sequencer next state, bitmap capture and result outputs
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = 1'b0;
        active_d    = active_q;
        overrun_d   = bus.timestep_end && !idle;

        // A spike coinciding with the snapshot lands in the fresh bitmap
        if (start) begin
            incoming_d = capture;
        end else begin
            incoming_d = incoming_q | capture;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.timestep_end) begin
                    active_d = incoming_q;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = StAccum;
                end
            end
            StAccum: begin
                if (active_q[idx_q]) begin
                    acc_d = sum_sat;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StDone: begin
                acc_out_d   = acc_q;
                acc_valid_d = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, bitmap and result registers; reset aborts any sum in flight
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            incoming_q  <= '0;
            active_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            overrun_q   <= overrun_d;
            incoming_q  <= incoming_d;
            active_q    <= active_d;
        end
    end

    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.busy      = !idle;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_synapse_accumulator.sv
// Bench for synapse_accumulator: a 24-bit-accumulator instance and a narrow 8-bit
// instance for saturation, both checked against a set-based reference model.
module tb_synapse_accumulator;

    logic CLK = 1'b0;
    logic reset;

    always #5 CLK = ~CLK;

    synapse_accumulator_if #(.N_CONN(5), .ADDR_W(12), .WEIGHT_W(16), .ACC_W(24)) bus ();
    synapse_accumulator_if #(.N_CONN(5), .ADDR_W(12), .WEIGHT_W(8), .ACC_W(8)) bus8 ();

    synapse_accumulator #(.N_CONN(5), .ADDR_W(12), .WEIGHT_W(16), .ACC_W(24)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    synapse_accumulator #(.N_CONN(5), .ADDR_W(12), .WEIGHT_W(8), .ACC_W(8)) dut8 (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: table contents and the set of addresses spiked this timestep
    int m_addr [2][5];
    int m_w    [2][5];
    bit m_en   [2][5];
    int spk_q  [2][$];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int sat_add(input int a, input int b, input int accw);
        int s;
        int mx;
        int mn;
        s  = a + b;
        mx = (1 << (accw - 1)) - 1;
        mn = -(1 << (accw - 1));
        if (s > mx) return mx;
        if (s < mn) return mn;
        return s;
    endfunction

    function automatic bit spiked(input int d, input int a);
        for (int k = 0; k < spk_q[d].size(); k++) begin
            if (spk_q[d][k] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int model_result(input int d);
        int acc;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (m_en[d][i] && spiked(d, m_addr[d][i])) begin
                acc = sat_add(acc, m_w[d][i], (d == 0) ? 24 : 8);
            end
        end
        return acc;
    endfunction

    function automatic bit vld(input int d);
        return (d == 0) ? bus.acc_valid : bus8.acc_valid;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 5; i++) begin
                m_addr[d][i] = 0;
                m_w[d][i]    = 0;
                m_en[d][i]   = 1'b0;
            end
            spk_q[d].delete();
        end
    endtask

    task automatic cfg(input int d, input int idx, input int addr, input int w, input bit en);
        if (d == 0) begin
            bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_addr = 12'(addr);
            bus.cfg_weight = 16'(w); bus.cfg_en = en;
        end else begin
            bus8.cfg_we = 1'b1; bus8.cfg_idx = 3'(idx); bus8.cfg_addr = 12'(addr);
            bus8.cfg_weight = 8'(w); bus8.cfg_en = en;
        end
        tick();
        bus.cfg_we  = 1'b0;
        bus8.cfg_we = 1'b0;
        if (idx < 5) begin
            m_addr[d][idx] = addr;
            m_w[d][idx]    = w;
            m_en[d][idx]   = en;
        end
    endtask

    task automatic spike(input int d, input int addr);
        if (d == 0) begin
            bus.spike_valid = 1'b1; bus.spike_addr = 12'(addr);
        end else begin
            bus8.spike_valid = 1'b1; bus8.spike_addr = 12'(addr);
        end
        tick();
        bus.spike_valid  = 1'b0;
        bus8.spike_valid = 1'b0;
        spk_q[d].push_back(addr);
    endtask

    // Close the timestep (optionally with a coincident spike) and wait for the result
    task automatic end_wait(input int d, input bit sv, input int sa, output int exp,
                            output int got, output int lat, output bit busy_seen);
        exp = model_result(d);
        spk_q[d].delete();
        if (sv) spk_q[d].push_back(sa);
        if (d == 0) begin
            bus.timestep_end = 1'b1; bus.spike_valid = sv; bus.spike_addr = 12'(sa);
        end else begin
            bus8.timestep_end = 1'b1; bus8.spike_valid = sv; bus8.spike_addr = 12'(sa);
        end
        tick();
        bus.timestep_end = 1'b0;  bus.spike_valid = 1'b0;
        bus8.timestep_end = 1'b0; bus8.spike_valid = 1'b0;
        busy_seen = (d == 0) ? bus.busy : bus8.busy;
        lat = 0;
        while (!vld(d) && lat < 30) begin
            tick();
            lat++;
        end
        got = (d == 0) ? int'($signed(bus.acc_out)) : int'($signed(bus8.acc_out));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.acc_out !== 24'd0 || bus.acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out acc_out=%0d acc_valid=%0b want 0/0", bus.acc_out, bus.acc_valid);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%0b overrun=%0b want 0/0", bus.busy, bus.overrun);
        end
        checks++;
        if (bus8.acc_out !== 8'd0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_narrow acc_out=%0d busy=%0b want 0/0", bus8.acc_out, bus8.busy);
        end
    endtask

    task automatic test_basic();
        int exp, got, lat;
        bit bs;
        cfg(0, 0, 3, 10, 1);
        cfg(0, 1, 4, 20, 1);
        cfg(0, 2, 5, -5, 1);
        cfg(0, 3, 6, 0, 1);
        cfg(0, 4, 7, 100, 1);
        spike(0, 3);
        spike(0, 5);
        spike(0, 7);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 105 || exp !== 105) begin
            errors++;
            $display("FAIL basic_sum got=%0d want 105 (model %0d)", got, exp);
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL basic_latency got=%0d want 6", lat);
        end
        checks++;
        if (bs !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got=%0b want 1", bs);
        end
        tick();
        checks++;
        if (bus.acc_valid !== 1'b0 || bus.busy !== 1'b0 || $signed(bus.acc_out) !== 24'sd105) begin
            errors++;
            $display("FAIL basic_pulse acc_valid=%0b busy=%0b acc_out=%0d want 0/0/105",
                     bus.acc_valid, bus.busy, bus.acc_out);
        end
    endtask

    task automatic test_duplicate();
        int exp, got, lat;
        bit bs;
        cfg(0, 0, 9, 7, 1);
        cfg(0, 1, 9, 8, 1);
        spike(0, 9);
        spike(0, 9);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 15 || exp !== 15) begin
            errors++;
            $display("FAIL dup_sum got=%0d want 15 (model %0d)", got, exp);
        end
        spike(0, 42);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 0 || lat !== 6) begin
            errors++;
            $display("FAIL unmapped got=%0d lat=%0d want 0 lat 6", got, lat);
        end
    endtask

    task automatic test_same_cycle();
        int exp, got, lat;
        bit bs;
        spike(0, 7);
        end_wait(0, 1'b1, 9, exp, got, lat, bs);
        checks++;
        if (got !== 100 || exp !== 100) begin
            errors++;
            $display("FAIL same_cycle_excl got=%0d want 100 (model %0d)", got, exp);
        end
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 15 || exp !== 15) begin
            errors++;
            $display("FAIL same_cycle_next got=%0d want 15 (model %0d)", got, exp);
        end
    endtask

    task automatic test_overrun();
        int ov, nv, exp, got, lat;
        bit bs;
        ov = 0;
        nv = 0;
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        if (bus.overrun) ov++;
        if (bus.acc_valid) nv++;
        tick();
        if (bus.overrun) ov++;
        if (bus.acc_valid) nv++;
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        if (bus.overrun) ov++;
        if (bus.acc_valid) nv++;
        // Busy-time write to entry 4 must be dropped
        bus.cfg_we = 1'b1; bus.cfg_idx = 3'd4; bus.cfg_addr = 12'd7;
        bus.cfg_weight = 16'd1; bus.cfg_en = 1'b1;
        tick();
        bus.cfg_we = 1'b0;
        if (bus.overrun) ov++;
        if (bus.acc_valid) nv++;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.overrun) ov++;
            if (bus.acc_valid) nv++;
        end
        checks++;
        if (ov !== 1) begin
            errors++;
            $display("FAIL overrun_count got=%0d want 1", ov);
        end
        checks++;
        if (nv !== 1) begin
            errors++;
            $display("FAIL overrun_valid_count got=%0d want 1", nv);
        end
        spk_q[0].delete();
        spike(0, 7);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 100 || exp !== 100) begin
            errors++;
            $display("FAIL cfg_locked got=%0d want 100 (model %0d)", got, exp);
        end
    endtask

    task automatic test_back_to_back();
        int ov, nv;
        ov = 0;
        nv = 0;
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.overrun) ov++;
            if (bus.acc_valid) nv++;
        end
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        if (bus.overrun) ov++;
        if (bus.acc_valid) nv++;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.overrun) ov++;
            if (bus.acc_valid) nv++;
        end
        checks++;
        if (ov !== 0 || nv !== 2) begin
            errors++;
            $display("FAIL back_to_back overrun=%0d valid=%0d want 0/2", ov, nv);
        end
    endtask

    task automatic test_random();
        int exp, got, lat, n;
        bit bs;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 4; c++) begin
                cfg(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
            end
            n = int'($urandom_range(0, 6));
            for (int s = 0; s < n; s++) spike(0, int'($urandom_range(0, 9)));
            end_wait(0, 1'b0, 0, exp, got, lat, bs);
            checks++;
            if (got !== exp || lat !== 6) begin
                errors++;
                $display("FAIL random_%0d got=%0d lat=%0d want %0d lat 6", r, got, lat, exp);
            end
        end
    endtask

    task automatic test_saturation();
        int exp, got, lat, n;
        bit bs;
        for (int i = 0; i < 5; i++) cfg(1, i, i + 1, 127, 1);
        for (int i = 0; i < 5; i++) spike(1, i + 1);
        end_wait(1, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 127 || exp !== 127) begin
            errors++;
            $display("FAIL sat_pos got=%0d want 127 (model %0d)", got, exp);
        end
        for (int i = 0; i < 5; i++) cfg(1, i, i + 1, -128, 1);
        for (int i = 0; i < 5; i++) spike(1, i + 1);
        end_wait(1, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== -128 || exp !== -128) begin
            errors++;
            $display("FAIL sat_neg got=%0d want -128 (model %0d)", got, exp);
        end
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 5; i++) begin
                cfg(1, i, i + 1, int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 3) != 0));
            end
            n = int'($urandom_range(1, 6));
            for (int s = 0; s < n; s++) spike(1, int'($urandom_range(1, 5)));
            end_wait(1, 1'b0, 0, exp, got, lat, bs);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL sat_random_%0d got=%0d want %0d", r, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        int exp, got, lat, nv;
        bit bs;
        cfg(0, 0, 1, 55, 1);
        spike(0, 1);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pre_reset got=%0d want %0d", got, exp);
        end
        spike(0, 1);
        bus.timestep_end = 1'b1;
        tick();
        bus.timestep_end = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        checks++;
        if (bus.busy !== 1'b0 || bus.acc_out !== 24'd0 || bus.acc_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%0b acc_out=%0d acc_valid=%0b want 0/0/0",
                     bus.busy, bus.acc_out, bus.acc_valid);
        end
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.acc_valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL reset_abort valid_pulses=%0d want 0", nv);
        end
        spike(0, 1);
        spike(0, 0);
        end_wait(0, 1'b0, 0, exp, got, lat, bs);
        checks++;
        if (got !== 0 || exp !== 0 || lat !== 6) begin
            errors++;
            $display("FAIL table_cleared got=%0d lat=%0d want 0 lat 6", got, lat);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.cfg_we = 1'b0;  bus.cfg_idx = '0;  bus.cfg_addr = '0;  bus.cfg_weight = '0;
        bus.cfg_en = 1'b0;  bus.spike_valid = 1'b0; bus.spike_addr = '0; bus.timestep_end = 1'b0;
        bus8.cfg_we = 1'b0; bus8.cfg_idx = '0; bus8.cfg_addr = '0; bus8.cfg_weight = '0;
        bus8.cfg_en = 1'b0; bus8.spike_valid = 1'b0; bus8.spike_addr = '0;
        bus8.timestep_end = 1'b0;
        tick();
        test_reset();
        test_basic();
        test_duplicate();
        test_same_cycle();
        test_overrun();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
